// File: rtl/core_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcodes, ALU op
// encodings, the instruction field layout and default widths.
package core_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_REG_AW  = 4;
  localparam int unsigned DEF_INSTR_W = 16;

  // Instruction opcodes (instr[15:12])
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;

  // ALU operation encodings presented on aluOp
  localparam logic [3:0] ALUOP_NOP = 4'b0000;
  localparam logic [3:0] ALUOP_ADD = 4'b0001;

  // Instruction word layout: rs2 doubles as imm4 for ADDI
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

endpackage : core_pkg

// File: rtl/operand_forward.sv
// Per-operand source select for the issue stage.
// Priority: r0 -> zero, then EX-stage result, then WB-stage data, then RF.
// Ports:
//   rs        : source register address being read
//   ex_we/ex_rd/ex_data : instruction currently in EX and its result
//   wb_we/wb_addr/wb_data : instruction currently in WB
//   rf_rdata  : register-file read data for rs
//   operand_c : selected operand (combinational)
module operand_forward
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] operand_c
);

  // Nearest producer wins so a back-to-back dependency sees the newest value.
  always_comb begin
    operand_c = rf_rdata;
    if (rs == '0) begin
      operand_c = '0;
    end else if (ex_we && (ex_rd == rs)) begin
      operand_c = ex_data;
    end else if (wb_we && (wb_addr == rs)) begin
      operand_c = wb_data;
    end
  end

endmodule : operand_forward

// File: rtl/alu_issue_stage.sv
// Issue and writeback stage in front of the 8-bit ALU.
// Decodes instructions into aluOp/srcA/srcB (ID/EX register), forwards
// operands from EX and WB, and captures alu_result into the EX/WB register
// that drives the register-file write port. Supports stall and flush.
// Optional: define ALU_ISSUE_PERF_EN to add 16-bit saturating counters
// perf_issued / perf_bubbles and their output ports.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid, instr  : incoming instruction; instr_ready = accept this cycle
//   stall, flush        : hold both pipeline registers / drop the accepted instr
//   rf_raddr_a/b        : RF read addresses (combinational from instr)
//   rf_rdata_a/b        : RF read data
//   aluOp, srcA, srcB   : registered ALU request
//   alu_result          : ALU output for the current request
//   wb_we/wb_addr/wb_data : RF write port
//   illegal_op          : one-cycle pulse on an accepted undefined opcode
module alu_issue_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [REG_AW-1:0]  rf_raddr_a,
  output logic [REG_AW-1:0]  rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic [3:0]         aluOp,
  output logic [DATA_W-1:0]  srcA,
  output logic [DATA_W-1:0]  srcB,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               wb_we,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0]        perf_issued,
  output logic [15:0]        perf_bubbles,
`endif
  output logic               illegal_op
);

  instr_t fields;
  logic   accept;

  logic [3:0]        aluop_q,   aluop_d;
  logic [DATA_W-1:0] srca_q,    srca_d;
  logic [DATA_W-1:0] srcb_q,    srcb_d;
  logic              ex_we_q,   ex_we_d;
  logic [REG_AW-1:0] ex_rd_q,   ex_rd_d;
  logic              wb_we_q,   wb_we_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W-1:0] opa_c;
  logic [DATA_W-1:0] opb_c;

  assign fields      = instr_t'(instr[15:0]);
  assign instr_ready = !stall && !rst;
  assign accept      = instr_valid && instr_ready;
  assign rf_raddr_a  = REG_AW'(fields.rs1);
  assign rf_raddr_b  = REG_AW'(fields.rs2);

  operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .rs        (rf_raddr_a),
    .ex_we     (ex_we_q),
    .ex_rd     (ex_rd_q),
    .ex_data   (alu_result),
    .wb_we     (wb_we_q),
    .wb_addr   (wb_addr_q),
    .wb_data   (wb_data_q),
    .rf_rdata  (rf_rdata_a),
    .operand_c (opa_c)
  );

  operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .rs        (rf_raddr_b),
    .ex_we     (ex_we_q),
    .ex_rd     (ex_rd_q),
    .ex_data   (alu_result),
    .wb_we     (wb_we_q),
    .wb_addr   (wb_addr_q),
    .wb_data   (wb_data_q),
    .rf_rdata  (rf_rdata_b),
    .operand_c (opb_c)
  );

  // Next state for ID/EX and EX/WB; everything holds while stalled.
  always_comb begin
    aluop_d   = aluop_q;
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    ex_we_d   = ex_we_q;
    ex_rd_d   = ex_rd_q;
    wb_we_d   = wb_we_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    illegal_d = 1'b0;
    if (!stall) begin
      // Bubble unless a legal instruction is accepted and not flushed.
      aluop_d = ALUOP_NOP;
      srca_d  = '0;
      srcb_d  = '0;
      ex_we_d = 1'b0;
      ex_rd_d = '0;
      if (accept && !flush) begin
        case (fields.opcode)
          OP_NOP: ;
          OP_ADD: begin
            aluop_d = ALUOP_ADD;
            srca_d  = opa_c;
            srcb_d  = opb_c;
            ex_rd_d = REG_AW'(fields.rd);
            ex_we_d = (fields.rd != 4'd0);
          end
          OP_ADDI: begin
            aluop_d = ALUOP_ADD;
            srca_d  = opa_c;
            srcb_d  = DATA_W'(fields.rs2);
            ex_rd_d = REG_AW'(fields.rd);
            ex_we_d = (fields.rd != 4'd0);
          end
          default: illegal_d = 1'b1;
        endcase
      end
      wb_we_d   = ex_we_q;
      wb_addr_d = ex_rd_q;
      wb_data_d = alu_result;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q   <= ALUOP_NOP;
      srca_q    <= '0;
      srcb_q    <= '0;
      ex_we_q   <= 1'b0;
      ex_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      aluop_q   <= aluop_d;
      srca_q    <= srca_d;
      srcb_q    <= srcb_d;
      ex_we_q   <= ex_we_d;
      ex_rd_q   <= ex_rd_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
    end
  end

  assign aluOp      = aluop_q;
  assign srcA       = srca_q;
  assign srcB       = srcb_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign illegal_op = illegal_q;
  // A held writeback must not repeat during stall; it fires on release.
  assign wb_we      = wb_we_q && !stall && !rst;

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] issued_q,  issued_d;
  logic [15:0] bubbles_q, bubbles_d;

  // Every non-stalled cycle exactly one of issue/bubble enters ID/EX.
  always_comb begin
    issued_d  = issued_q;
    bubbles_d = bubbles_q;
    if (!stall) begin
      if (aluop_d != ALUOP_NOP) begin
        if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
      end else begin
        if (bubbles_q != 16'hFFFF) bubbles_d = bubbles_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      bubbles_q <= '0;
    end else begin
      issued_q  <= issued_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule : alu_issue_stage
